// File: rtl/clock24_pkg.sv
// Shared definitions for the 24-hour clock time-of-day core:
// set-mode state encoding, BCD field width/constants and BCD helpers.
package clock24_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } cnt24h_state_t;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] BCD_59 = 8'h59;
    localparam logic [BCD_W-1:0] BCD_00 = 8'h00;

    // Convert a small integer (0..99) to packed two-digit BCD.
    function automatic logic [BCD_W-1:0] to_bcd8(input int val);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(val / 10);
        ones = 4'(val % 10);
        return {tens, ones};
    endfunction

    // Digit-wise BCD increment: ones 9 -> 0 carries into tens.
    // Field wrap (59, hour max) is handled by the caller on the full value.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] val);
        logic [BCD_W-1:0] res;
        if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd60_cnt.sv
// Two-digit BCD modulo-60 counter used for both seconds and minutes.
// clr has priority over inc; wrap flags the 59 -> 00 transition combinationally.
module bcd60_cnt
    import clock24_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] value,
    output logic             wrap
);

    logic [BCD_W-1:0] value_reg;

    // Counter register: reset/clear to 00, otherwise BCD increment with wrap at 59.
    always_ff @(posedge CLK) begin
        if (RST) begin
            value_reg <= BCD_00;
        end else if (clr) begin
            value_reg <= BCD_00;
        end else if (inc) begin
            if (value_reg == BCD_59) begin
                value_reg <= BCD_00;
            end else begin
                value_reg <= bcd_step(value_reg);
            end
        end
    end

    assign value = value_reg;
    assign wrap  = inc && (value_reg == BCD_59);

endmodule

// File: rtl/cnt24h.sv
// Time-of-day core of the 24-hour clock: BCD seconds/minutes/hours advanced by
// EN1HZ, with a MODE/INC set-mode state machine (hour -> min -> sec -> normal).
// Optional feature macro: CNT24H_BLINK_EN -- when defined, BLANK blinks the
// field being edited using SIG2HZ; otherwise BLANK is tied low and SIG2HZ unused.
module cnt24h
    import clock24_pkg::*;
#(
    parameter int HOUR_MAX = 23
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN1HZ,
    input  logic             SIG2HZ,
    input  logic             MODE,
    input  logic             INC,
    output logic [BCD_W-1:0] SEC_BCD,
    output logic [BCD_W-1:0] MIN_BCD,
    output logic [BCD_W-1:0] HOUR_BCD,
    output logic [2:0]       BLANK,
    output logic             SETTING,
    output logic             CARRY_DAY
);

    localparam logic [BCD_W-1:0] HOUR_MAX_BCD = to_bcd8(HOUR_MAX);

    cnt24h_state_t    state_reg;
    cnt24h_state_t    state_next;
    logic             setting_comb;
    logic [2:0]       sel_mask;

    logic             sec_inc;
    logic             sec_clr;
    logic             sec_wrap;
    logic             min_inc;
    logic             min_wrap;
    logic             hour_inc;
    logic             hour_carry;
    logic [BCD_W-1:0] sec_val;
    logic [BCD_W-1:0] min_val;
    logic [BCD_W-1:0] hour_reg;
    logic             carry_day_reg;
    logic [2:0]       blank_reg;

    // State register for the set-mode sequence.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= NORMAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: each MODE pulse advances one step around the ring.
    always_comb begin
        state_next = state_reg;
        if (MODE) begin
            case (state_reg)
                NORMAL:   state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                SET_SEC:  state_next = NORMAL;
                default:  state_next = NORMAL;
            endcase
        end
    end

    // State outputs: SETTING flag and one-hot mask of the field being edited.
    always_comb begin
        setting_comb = 1'b0;
        sel_mask     = 3'b000;
        case (state_reg)
            SET_HOUR: begin
                setting_comb = 1'b1;
                sel_mask     = 3'b100;
            end
            SET_MIN: begin
                setting_comb = 1'b1;
                sel_mask     = 3'b010;
            end
            SET_SEC: begin
                setting_comb = 1'b1;
                sel_mask     = 3'b001;
            end
            default: begin
                setting_comb = 1'b0;
                sel_mask     = 3'b000;
            end
        endcase
    end

    // Increment/clear strobes. Ticks only count in NORMAL; in set states INC
    // edits the current (pre-transition) field and never carries upward.
    assign sec_inc    = (state_reg == NORMAL) && EN1HZ;
    assign sec_clr    = (state_reg == SET_SEC) && INC;
    assign min_inc    = sec_wrap || ((state_reg == SET_MIN) && INC);
    assign hour_carry = (state_reg == NORMAL) && min_wrap;
    assign hour_inc   = hour_carry || ((state_reg == SET_HOUR) && INC);

    bcd60_cnt u_sec (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .value (sec_val),
        .wrap  (sec_wrap)
    );

    bcd60_cnt u_min (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (min_val),
        .wrap  (min_wrap)
    );

    // Hour counter: BCD increment, wrap from HOUR_MAX to 00 on the full value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hour_reg <= BCD_00;
        end else if (hour_inc) begin
            if (hour_reg == HOUR_MAX_BCD) begin
                hour_reg <= BCD_00;
            end else begin
                hour_reg <= bcd_step(hour_reg);
            end
        end
    end

    // Day carry: one-cycle pulse after the tick that rolls HOUR_MAX:59:59 over.
    always_ff @(posedge CLK) begin
        if (RST) begin
            carry_day_reg <= 1'b0;
        end else begin
            carry_day_reg <= hour_carry && (hour_reg == HOUR_MAX_BCD);
        end
    end

`ifdef CNT24H_BLINK_EN
    logic [2:0] blank_next;

    for (genvar gi = 0; gi < 3; gi++) begin : g_blank
        assign blank_next[gi] = sel_mask[gi] & ~SIG2HZ;
    end

    // Registered blink request for the selected field.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blank_reg <= 3'b000;
        end else begin
            blank_reg <= blank_next;
        end
    end
`else
    // Blinking disabled: the field being edited is shown only via SETTING.
    logic       unused_sig2hz;
    logic [2:0] unused_sel_mask;

    assign unused_sig2hz   = SIG2HZ;
    assign unused_sel_mask = sel_mask;
    assign blank_reg       = 3'b000;
`endif

    assign SEC_BCD   = sec_val;
    assign MIN_BCD   = min_val;
    assign HOUR_BCD  = hour_reg;
    assign BLANK     = blank_reg;
    assign SETTING   = setting_comb;
    assign CARRY_DAY = carry_day_reg;

endmodule

// File: tb/tb_cnt24h.sv
// Directed self-checking bench for cnt24h: counting, cascade wrap with day
// carry, set-mode editing, simultaneous events, blink and mid-edit reset.
module tb_cnt24h;

    logic       CLK;
    logic       RST;
    logic       EN1HZ;
    logic       SIG2HZ;
    logic       MODE;
    logic       INC;
    logic [7:0] SEC_BCD;
    logic [7:0] MIN_BCD;
    logic [7:0] HOUR_BCD;
    logic [2:0] BLANK;
    logic       SETTING;
    logic       CARRY_DAY;

    int checks_cnt;
    int fail_cnt;

`ifdef CNT24H_BLINK_EN
    localparam logic [2:0] BLK_SEC  = 3'b001;
    localparam logic [2:0] BLK_MIN  = 3'b010;
    localparam logic [2:0] BLK_HOUR = 3'b100;
`else
    localparam logic [2:0] BLK_SEC  = 3'b000;
    localparam logic [2:0] BLK_MIN  = 3'b000;
    localparam logic [2:0] BLK_HOUR = 3'b000;
`endif

    cnt24h #(
        .HOUR_MAX (23)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN1HZ     (EN1HZ),
        .SIG2HZ    (SIG2HZ),
        .MODE      (MODE),
        .INC       (INC),
        .SEC_BCD   (SEC_BCD),
        .MIN_BCD   (MIN_BCD),
        .HOUR_BCD  (HOUR_BCD),
        .BLANK     (BLANK),
        .SETTING   (SETTING),
        .CARRY_DAY (CARRY_DAY)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // One clock: drive pulses, clock edge, sample 1 time unit after the edge.
    task automatic step(input logic en, input logic md, input logic ic);
        EN1HZ = en;
        MODE  = md;
        INC   = ic;
        @(posedge CLK);
        #1;
        EN1HZ = 1'b0;
        MODE  = 1'b0;
        INC   = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        RST    = 1'b1;
        EN1HZ  = 1'b0;
        SIG2HZ = 1'b0;
        MODE   = 1'b0;
        INC    = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;

        check("rst_sec",   SEC_BCD, 8'h00);
        check("rst_min",   MIN_BCD, 8'h00);
        check("rst_hour",  HOUR_BCD, 8'h00);
        check("rst_set",   {7'd0, SETTING}, 8'h00);
        check("rst_blank", {5'd0, BLANK}, 8'h00);
        check("rst_carry", {7'd0, CARRY_DAY}, 8'h00);

        // 60 ticks: seconds run 00..59..00, minute carries once.
        for (int i = 1; i <= 60; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 1)  check("tick1_sec", SEC_BCD, 8'h01);
            if (i == 10) check("tick10_sec", SEC_BCD, 8'h10);
            if (i == 59) check("tick59_sec", SEC_BCD, 8'h59);
            if (i == 59) check("tick59_min", MIN_BCD, 8'h00);
        end
        check("tick60_sec",  SEC_BCD, 8'h00);
        check("tick60_min",  MIN_BCD, 8'h01);
        check("tick60_hour", HOUR_BCD, 8'h00);

        // INC ignored in NORMAL.
        step(1'b0, 1'b0, 1'b1);
        check("norm_inc_min", MIN_BCD, 8'h01);

        // Preload 23:59:00 in set mode, then tick to 23:59:58.
        step(1'b0, 1'b1, 1'b0);
        check("sethour_set", {7'd0, SETTING}, 8'h01);
        for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 1'b1);
        check("pre_hour", HOUR_BCD, 8'h23);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 58; i++) step(1'b0, 1'b0, 1'b1);
        check("pre_min", MIN_BCD, 8'h59);
        check("pre_hour_keep", HOUR_BCD, 8'h23);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("back_normal", {7'd0, SETTING}, 8'h00);
        for (int i = 0; i < 58; i++) step(1'b1, 1'b0, 1'b0);
        check("pre_sec", SEC_BCD, 8'h58);
        step(1'b1, 1'b0, 1'b0);
        check("t59_sec", SEC_BCD, 8'h59);
        check("t59_carry", {7'd0, CARRY_DAY}, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        check("wrap_sec",   SEC_BCD, 8'h00);
        check("wrap_min",   MIN_BCD, 8'h00);
        check("wrap_hour",  HOUR_BCD, 8'h00);
        check("wrap_carry", {7'd0, CARRY_DAY}, 8'h01);
        step(1'b0, 1'b0, 1'b0);
        check("carry_drop", {7'd0, CARRY_DAY}, 8'h00);

        // EN1HZ + MODE in NORMAL: tick applied and state moves to SET_HOUR.
        step(1'b1, 1'b1, 1'b0);
        check("tickmode_sec", SEC_BCD, 8'h01);
        check("tickmode_set", {7'd0, SETTING}, 8'h01);

        // SET_HOUR: 25 INCs with ticks alongside -> hour 01, seconds frozen.
        SIG2HZ = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (i == 10) check("hinc10", HOUR_BCD, 8'h10);
            if (i == 24) check("hinc24_wrap", HOUR_BCD, 8'h00);
        end
        check("hinc25_hour", HOUR_BCD, 8'h01);
        check("hinc25_sec",  SEC_BCD, 8'h01);
        check("hinc25_carry", {7'd0, CARRY_DAY}, 8'h00);
        check("blank_hour", {5'd0, BLANK}, {5'd0, BLK_HOUR});

        // MODE + INC: INC acts on hour, then state becomes SET_MIN.
        step(1'b0, 1'b1, 1'b1);
        check("modeinc_hour", HOUR_BCD, 8'h02);
        check("modeinc_min",  MIN_BCD, 8'h00);

        // SET_MIN: 59 -> 00 without carry into hours.
        for (int i = 0; i < 59; i++) step(1'b0, 1'b0, 1'b1);
        check("smin_59", MIN_BCD, 8'h59);
        step(1'b0, 1'b0, 1'b1);
        check("smin_wrap", MIN_BCD, 8'h00);
        check("smin_hour", HOUR_BCD, 8'h02);

        // Back to NORMAL, tick seconds to 37, then enter SET_SEC.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 36; i++) step(1'b1, 1'b0, 1'b0);
        check("sec37", SEC_BCD, 8'h37);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        SIG2HZ = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("blank_sec_lo", {5'd0, BLANK}, {5'd0, BLK_SEC});
        SIG2HZ = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("blank_sec_hi", {5'd0, BLANK}, 8'h00);
        check("ssec_hold", SEC_BCD, 8'h37);
        step(1'b0, 1'b0, 1'b1);
        check("ssec_clr", SEC_BCD, 8'h00);
        SIG2HZ = 1'b0;
        step(1'b0, 1'b1, 1'b0);

        // Build 12:34:56, enter SET_MIN, then reset mid-edit.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 56; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("t123456_hour", HOUR_BCD, 8'h12);
        check("t123456_min",  MIN_BCD, 8'h34);
        check("t123456_sec",  SEC_BCD, 8'h56);
        check("blank_min", {5'd0, BLANK}, {5'd0, BLK_MIN});
        RST = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        RST = 1'b0;
        check("mrst_sec",   SEC_BCD, 8'h00);
        check("mrst_min",   MIN_BCD, 8'h00);
        check("mrst_hour",  HOUR_BCD, 8'h00);
        check("mrst_set",   {7'd0, SETTING}, 8'h00);
        check("mrst_blank", {5'd0, BLANK}, 8'h00);
        step(1'b1, 1'b0, 1'b0);
        check("post_rst_tick", SEC_BCD, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/cnt24h.md
# cnt24h

Time-of-day core of the 24-hour clock, directly downstream of the 1 Hz / 2 Hz timing generator. Consumes `EN1HZ` to advance BCD seconds, minutes and hours, and `SIG2HZ` to blink the field being edited. A MODE/INC button pair sets the time. BCD outputs feed the 7-segment decoder stage.

## Interface
- `HOUR_MAX`, default 23: highest hour value before wrap to 00; legal range 1..23.
- `CLK`  in  1: system clock, 50 MHz.
- `RST`  in  1: synchronous, active-high reset.
- `EN1HZ`  in  1: one-cycle tick, once per second.
- `SIG2HZ`  in  1: 2 Hz, 50 % duty blink reference.
- `MODE`  in  1: debounced one-cycle pulse; advances the set-mode state.
- `INC`  in  1: debounced one-cycle pulse; edits the selected field.
- `SEC_BCD`  out  8: seconds, `{tens[3:0], ones[3:0]}`, 00..59.
- `MIN_BCD`  out  8: minutes, 00..59.
- `HOUR_BCD`  out  8: hours, 00..`HOUR_MAX`.
- `BLANK`  out  3: per-field blank request; bit0 sec, bit1 min, bit2 hour.
- `SETTING`  out  1: high in any set state.
- `CARRY_DAY`  out  1: one-cycle pulse on wrap from `HOUR_MAX`:59:59 to 00:00:00.

## Operation
- State machine: `NORMAL` → `SET_HOUR` → `SET_MIN` → `SET_SEC` → `NORMAL`.
  - Each `MODE` pulse advances one step.
  - No other transitions.
- `NORMAL`:
  - `EN1HZ` increments seconds.
  - Seconds wrap 59→00 increments minutes.
  - Minutes wrap increments hours.
  - Hours wrap `HOUR_MAX`→00.
  - `INC` is ignored.
- Set states:
  - `EN1HZ` is ignored; time is frozen.
  - `SET_HOUR` + `INC`: hour +1, wraps `HOUR_MAX`→00. No carry into any other field.
  - `SET_MIN` + `INC`: minute +1, wraps 59→00. No carry into hours.
  - `SET_SEC` + `INC`: seconds cleared to 00, independent of current value.
- BCD arithmetic:
  - Ones digit 9→0 increments tens.
  - Field wrap is detected on the full BCD value (59, or BCD(`HOUR_MAX`)).
  - Never binary add on the packed byte.
- `BLANK`: in a set state, the selected field's bit = `~SIG2HZ`; all other bits 0. In `NORMAL`, `BLANK` = 0.
- `SETTING` = (state != `NORMAL`).

## Timing
- Reset values:
  - All BCD outputs 8'h00.
  - state `NORMAL`, `SETTING` 0, `BLANK` 3'b000, `CARRY_DAY` 0.
- Reset takes priority over every other input in the same cycle.
- Reset mid-edit returns to `NORMAL` at 00:00:00.
- Latency:
  - `EN1HZ`/`INC` sampled at edge N; updated BCD value visible after edge N (1 cycle).
  - `CARRY_DAY` is high for exactly the cycle following the wrapping tick.
- State registered: `MODE` at edge N changes `SETTING` after edge N.
- `BLANK` is registered; it lags `SIG2HZ` by 1 cycle.
- Simultaneous events:
  - `EN1HZ` + `MODE` in `NORMAL`: the tick is applied and the state moves to `SET_HOUR` on the same edge.
  - `MODE` + `INC` in a set state: `INC` acts on the current (pre-transition) field.
  - `EN1HZ` + `INC` in a set state: only `INC` acts.
- Full cascade 23:59:59 → 00:00:00 completes on a single edge.

## Configuration
- `CNT24H_BLINK_EN` defined:
  - `BLANK` behaves as above.
  - `SIG2HZ` is used.
- `CNT24H_BLINK_EN` undefined:
  - `BLANK` is tied to 3'b000.
  - `SIG2HZ` is unused; port retained.
  - The selected field is indicated only by `SETTING`.

## Structure
- Shared package `clock24_pkg`:
  - state enum `cnt24h_state_t` (2 bits: `NORMAL`=0, `SET_HOUR`=1, `SET_MIN`=2, `SET_SEC`=3).
  - `BCD_W` = 8.
  - constants `BCD_59` = 8'h59 and `BCD_00`.
- Sub-module `bcd60_cnt`, instantiated twice (sec, min):
  - Inputs: `CLK`, `RST`, `inc`, `clr`.
  - Outputs: 8-bit BCD value and `wrap` (comb, = `inc` && value == 59).
- Hour counter and state machine stay in `cnt24h`.

## Test plan
- Reset, then 60 `EN1HZ` ticks → `SEC_BCD` 00→59→00, `MIN_BCD` = 8'h01, `HOUR_BCD` = 8'h00.
- Preload 23:59:58 via set mode, return to `NORMAL`, 2 ticks → 23:59:59, then 00:00:00 with a single `CARRY_DAY` pulse.
- `MODE` ×1, `INC` ×25 → `HOUR_BCD` = 8'h01 (wrap at 23); `EN1HZ` pulses meanwhile leave seconds unchanged.
- `SET_MIN` with `MIN_BCD` = 8'h59, `INC` → 8'h00, `HOUR_BCD` unchanged.
- `SET_SEC` at 8'h37, `INC` → 8'h00. With `CNT24H_BLINK_EN`, `BLANK` = 3'b001 while `SIG2HZ` = 0, and 3'b000 while `SIG2HZ` = 1.
- Assert `RST` while in `SET_MIN` at 12:34:56 → next cycle 00:00:00, `SETTING` = 0, `BLANK` = 0.
